// File: rtl/array_reduce_pkg.sv
// array_reduce_pkg: shared types and reduction helpers for the array reduce engine.
package array_reduce_pkg;

    typedef enum logic [2:0] {OP_SUM, OP_PRODUCT, OP_AND, OP_OR, OP_XOR, OP_MIN, OP_MAX} op_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

    localparam int MAXW = 64;

    typedef struct packed {
        logic [MAXW-1:0] data;
        logic [31:0]     idx;
    } red_t;

    function automatic logic [MAXW-1:0] wmask(input int wb);
        return (wb >= MAXW) ? '1 : (MAXW'(1) << wb) - MAXW'(1);
    endfunction

    function automatic logic [MAXW-1:0] identity(input op_t op, input logic sgn, input int wb);
        logic [MAXW-1:0] m;
        logic [MAXW-1:0] msb;
        m   = wmask(wb);
        msb = MAXW'(1) << (wb - 1);
        case (op)
            OP_PRODUCT: identity = MAXW'(1);
            OP_AND:     identity = m;
            OP_MIN:     identity = sgn ? (m >> 1) : m;
            OP_MAX:     identity = sgn ? msb : '0;
            default:    identity = '0;
        endcase
    endfunction

    // Operands are zero-extended wb-bit values; signed compares left-align them first.
    function automatic red_t combine(input op_t op, input logic sgn, input int wb,
                                     input logic [MAXW-1:0] acc, input logic [MAXW-1:0] elem,
                                     input logic [31:0] acc_idx, input logic [31:0] elem_idx);
        logic [MAXW-1:0] m;
        logic            lt;
        logic            gt;
        int              sh;
        m  = wmask(wb);
        sh = MAXW - wb;
        lt = sgn ? ($signed(elem << sh) < $signed(acc << sh)) : (elem < acc);
        gt = sgn ? ($signed(elem << sh) > $signed(acc << sh)) : (elem > acc);
        combine.data = acc;
        combine.idx  = acc_idx;
        case (op)
            OP_SUM:     combine.data = (acc + elem) & m;
            OP_PRODUCT: combine.data = (acc * elem) & m;
            OP_AND:     combine.data = acc & elem;
            OP_OR:      combine.data = acc | elem;
            OP_XOR:     combine.data = acc ^ elem;
            OP_MIN:     if (lt) begin combine.data = elem; combine.idx = elem_idx; end
            OP_MAX:     if (gt) begin combine.data = elem; combine.idx = elem_idx; end
            default:    combine.data = acc;
        endcase
    endfunction

endpackage

// File: rtl/array_reduce_mem.sv
// array_reduce_mem: WA x WB flop array, one synchronous write port, one combinational read port.
module array_reduce_mem #(
    parameter int WA = 8,
    parameter int WB = 8,
    parameter int AW = $clog2(WA)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [WB-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [WB-1:0] o_rd_data
);

    logic [WB-1:0] r_mem [WA];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '{default: '0};
        end else if (i_wr_en && (32'(i_wr_addr) < WA)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/array_reduce_engine.sv
// array_reduce_engine: register-file array with a one-element-per-clock reduction unit
// answering sum/product/and/or/xor/min/max requests over a valid/ready response channel.
module array_reduce_engine
    import array_reduce_pkg::*;
#(
    parameter  int WA = 8,
    parameter  int WB = 8,
    localparam int AW = $clog2(WA),
    localparam int LW = $clog2(WA + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [WB-1:0] wr_data,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic          cmd_signed,
    input  logic [LW-1:0] cmd_len,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [WB-1:0] rsp_data,
    output logic [AW-1:0] rsp_index,
    output logic          rsp_empty
);

    state_t          r_state;
    state_t          w_next;
    op_t             r_op;
    logic            r_sgn;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_idx;
    logic [WB-1:0]   r_acc;
    logic [AW-1:0]   r_win;
    logic            r_empty;
    logic [WB-1:0]   w_rd;
    logic [LW-1:0]   w_len;
    logic [MAXW-1:0] w_id;
    red_t            w_c;

    array_reduce_mem #(.WA(WA), .WB(WB), .AW(AW)) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_idx[AW-1:0]),
        .o_rd_data (w_rd)
    );

    always_comb begin
        w_next    = r_state;
        cmd_ready = (r_state == S_IDLE);
        rsp_valid = (r_state == S_RESP);
        w_len     = (cmd_len > LW'(WA)) ? LW'(WA) : cmd_len;
        w_id      = identity(op_t'(cmd_op), cmd_signed, WB);
        w_c       = combine(r_op, r_sgn, WB, MAXW'(r_acc), MAXW'(w_rd), 32'(r_win), 32'(r_idx));
        case (r_state)
            S_IDLE:  w_next = cmd_valid ? S_RUN : S_IDLE;
            S_RUN:   w_next = (r_idx == r_len) ? S_RESP : S_RUN;
            S_RESP:  w_next = rsp_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // RUN spends one extra cycle on idx==len so the response lands len'+1 cycles after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_SUM;
            r_sgn   <= 1'b0;
            r_len   <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_win   <= '0;
            r_empty <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && cmd_valid) begin
                r_op    <= op_t'(cmd_op);
                r_sgn   <= cmd_signed;
                r_len   <= w_len;
                r_idx   <= '0;
                r_acc   <= w_id[WB-1:0];
                r_win   <= '0;
                r_empty <= (w_len == '0);
            end else if (r_state == S_RUN && r_idx != r_len) begin
                r_acc <= w_c.data[WB-1:0];
                r_win <= w_c.idx[AW-1:0];
                r_idx <= r_idx + LW'(1);
            end
        end
    end

    assign rsp_data  = r_acc;
    assign rsp_index = r_win;
    assign rsp_empty = r_empty;

endmodule

// File: tb/tb_array_reduce_engine.sv
// tb_array_reduce_engine: directed vectors with a scoreboard queue and an independent response monitor.
module tb_array_reduce_engine;
    import array_reduce_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic [2:0] idx;
        logic       empty;
        int         lat;
    } exp_t;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       wr_en = 0;
    logic [2:0] wr_addr = 0;
    logic [7:0] wr_data = 0;
    logic       cmd_valid = 0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 0;
    logic       cmd_signed = 0;
    logic [3:0] cmd_len = 0;
    logic       rsp_valid;
    logic       rsp_ready = 1;
    logic [7:0] rsp_data;
    logic [2:0] rsp_index;
    logic       rsp_empty;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic prev_v = 0;
    logic hs = 0;
    logic [7:0] h_data;
    logic [2:0] h_idx;
    logic       h_empty;

    array_reduce_engine #(.WA(8), .WB(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_signed(cmd_signed),
        .cmd_len(cmd_len), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_index(rsp_index), .rsp_empty(rsp_empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on each response handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 0;
            hs = 0;
        end else begin
            if (hs) begin
                chk("cmd_ready_after_hs", cmd_ready, 1);
                hs = 0;
            end
            if (cmd_valid && cmd_ready) acc_cyc = cyc + 1;
            if (rsp_valid) begin
                chk("cmd_ready_low_in_resp", cmd_ready, 0);
                if (!prev_v) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got data %0h with empty scoreboard", rsp_data);
                    end else begin
                        chk("latency", cyc - acc_cyc, sb[0].lat);
                    end
                end else begin
                    chk("hold_data", rsp_data, h_data);
                    chk("hold_idx", rsp_index, h_idx);
                    chk("hold_empty", rsp_empty, h_empty);
                end
                h_data = rsp_data;
                h_idx = rsp_index;
                h_empty = rsp_empty;
                if (rsp_ready && sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_index", rsp_index, e.idx);
                    chk("rsp_empty", rsp_empty, e.empty);
                    hs = 1;
                end
            end
            prev_v = rsp_valid;
        end
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1 wr_en = 0;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 8; i++) wr(3'(i), 8'(i + 1));
    endtask

    // Returns one time unit after the accept edge.
    task automatic run(input op_t op, input logic sgn, input int len, input logic [7:0] d,
                       input logic [2:0] ix, input logic push);
        exp_t e;
        int   k;
        e.data = d;
        e.idx = ix;
        e.empty = (len == 0);
        e.lat = ((len > 8) ? 8 : len) + 1;
        if (push) sb.push_back(e);
        cmd_op = op;
        cmd_signed = sgn;
        cmd_len = 4'(len);
        cmd_valid = 1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        if (k == 200) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 200; k++) begin
            @(posedge clk);
            if (sb.size() == 0 && cmd_ready) break;
        end
        if (k == 200) chk("done_timeout", 0, 1);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_index", rsp_index, 0);
        chk("reset_rsp_empty", rsp_empty, 0);
        rst_n = 1;
        @(posedge clk);
        #1;
        init_mem();
        run(OP_SUM, 0, 8, 8'h24, 0, 1);     wait_done();
        run(OP_PRODUCT, 0, 8, 8'h80, 0, 1); wait_done();
        run(OP_AND, 0, 8, 8'h00, 0, 1);     wait_done();
        run(OP_OR, 0, 8, 8'h0F, 0, 1);      wait_done();
        run(OP_XOR, 0, 8, 8'h08, 0, 1);     wait_done();
        run(OP_MIN, 0, 8, 8'h01, 0, 1);     wait_done();
        run(OP_MAX, 0, 8, 8'h08, 7, 1);     wait_done();
        wr(3, 8'hFF);
        run(OP_MAX, 0, 8, 8'hFF, 3, 1);     wait_done();
        run(OP_MIN, 1, 8, 8'hFF, 3, 1);     wait_done();
        run(OP_MAX, 1, 8, 8'h08, 7, 1);     wait_done();
        init_mem();
        run(OP_SUM, 0, 0, 8'h00, 0, 1);     wait_done();
        run(OP_SUM, 0, 3, 8'h06, 0, 1);     wait_done();
        run(OP_SUM, 0, 15, 8'h24, 0, 1);    wait_done();
        rsp_ready = 0;
        run(OP_SUM, 0, 8, 8'h24, 0, 1);
        repeat (19) @(posedge clk);
        #1;
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_cmd_ready", cmd_ready, 0);
        rsp_ready = 1;
        wait_done();
        run(OP_SUM, 0, 8, 8'h1D, 0, 1);
        @(posedge clk);
        #1 wr(6, 8'h00);
        wait_done();
        init_mem();
        run(OP_SUM, 0, 8, 8'h24, 0, 1);
        wr(0, 8'h00);
        wait_done();
        init_mem();
        for (int i = 0; i < 8; i++) wr(3'(i), 8'h05);
        run(OP_MIN, 0, 8, 8'h05, 0, 1);     wait_done();
        init_mem();
        run(OP_SUM, 0, 8, 8'h00, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_rsp_data", rsp_data, 0);
        chk("midrst_rsp_index", rsp_index, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        run(OP_SUM, 0, 8, 8'h00, 0, 1);     wait_done();
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
